matvec_ctrl: RTL and testbench

MATVEC_CTRL -- requirements
Module: matvec_ctrl

---
 rtl/matvec_ctrl.sv | 102 ++++++++++
 tb/tb_matvec_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/matvec_ctrl.sv
// Flow controller for a LAT-deep matvec_mul pipeline: tracks valid/last bits, stalls via cen,
// and freezes an empty pipeline on request so the weights can be rewritten safely.
module matvec_ctrl #(
  parameter int C     = 8,
  parameter int W_CNT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             cen,
  input  logic             upd_req,
  output logic             upd_gnt,
  output logic             busy,
  output logic [W_CNT-1:0] frame_cnt
);

  localparam int LAT = $clog2(C) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, UPD} state_t;

  state_t           state_q, state_d;
  logic [LAT-1:0]   vld_q, vld_d;
  logic [LAT-1:0]   lst_q, lst_d;
  logic [W_CNT-1:0] frame_cnt_q, frame_cnt_d;
  logic             accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vld_q       <= '0;
      lst_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      vld_q       <= vld_d;
      lst_q       <= lst_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Output process: every handshake/control output is forced low while reset is held.
  always_comb begin
    cen     = 1'b0;
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    upd_gnt = 1'b0;
    busy    = 1'b0;
    if (!rst) begin
      cen     = (state_q != UPD) && !(vld_q[LAT-1] && !m_ready);
      s_ready = cen && (state_q == IDLE || state_q == RUN) && !upd_req;
      m_valid = vld_q[LAT-1];
      m_last  = vld_q[LAT-1] && lst_q[LAT-1];
      upd_gnt = (state_q == UPD);
      busy    = (state_q != IDLE);
    end
  end

  assign accept    = s_valid && s_ready;
  assign frame_cnt = frame_cnt_q;

  always_comb begin
    vld_d       = vld_q;
    lst_d       = lst_q;
    frame_cnt_d = frame_cnt_q;
    if (cen) begin
      vld_d = {vld_q[LAT-2:0], accept};
      lst_d = {lst_q[LAT-2:0], accept && s_last};
    end
    if (m_valid && m_ready && m_last) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  // Next-state process; RUN looks at the post-shift valid bits so a lone vector exits promptly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (upd_req)     state_d = UPD;
        else if (accept) state_d = RUN;
      end
      RUN: begin
        if (upd_req)                        state_d = DRAIN;
        else if (vld_d == '0 && !accept)    state_d = IDLE;
      end
      DRAIN: begin
        if (vld_q == '0) state_d = UPD;
      end
      UPD: begin
        if (!upd_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_matvec_ctrl.sv
// Bench for matvec_ctrl: directed cycle table, hand sequences for update/reset/wrap, and random
// traffic checked against a tagged datapath model plus an in-order scoreboard.
module tb_matvec_ctrl;

  localparam int C     = 8;
  localparam int W_CNT = 8;
  localparam int LAT   = $clog2(C) + 1;

  logic             clk = 1'b0;
  logic             rst, s_valid, s_ready, s_last, m_valid, m_ready, m_last;
  logic             cen, upd_req, upd_gnt, busy;
  logic [W_CNT-1:0] frame_cnt;

  matvec_ctrl #(.C(C), .W_CNT(W_CNT)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .cen(cen),
    .upd_req(upd_req), .upd_gnt(upd_gnt), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] in;   // {s_valid, s_last, m_ready, upd_req}
    logic [5:0] exp;  // {s_ready, m_valid, m_last, cen, busy, upd_gnt}
  } vec_t;

  typedef struct {
    int tag;
    bit last;
  } item_t;

  int    checks = 0;
  int    errors = 0;
  vec_t  tbl[$];
  item_t sb[$];
  int    dp[LAT];
  int    next_tag = 0;
  int    fcnt = 0;
  int    hs_total = 0;
  bit    stall_prev = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] in, input logic [5:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic drive(input bit sv, input bit sl, input bit mr, input bit ur, input bit r);
    @(negedge clk);
    s_valid = sv;
    s_last  = sl;
    m_ready = mr;
    upd_req = ur;
    rst     = r;
    #1;
  endtask

  function automatic int outs();
    return int'({s_ready, m_valid, m_last, cen, busy, upd_gnt});
  endfunction

  // Checks the current cycle against the model, then advances one clock.
  task automatic tick();
    bit    acc, c, hs, sl;
    item_t e;
    chk("frame_cnt", int'(frame_cnt), fcnt);
    acc = s_valid && s_ready;
    c   = cen;
    hs  = m_valid && m_ready;
    sl  = s_last;
    if (rst) begin
      chk("outs_in_reset", outs(), 0);
    end else begin
      chk("cen_rule", int'(cen), int'(!upd_gnt && !(m_valid && !m_ready)));
      chk("s_ready_rule", int'(s_ready && (upd_req || !cen || upd_gnt)), 0);
      if (upd_gnt) chk("gnt_pipe_empty", sb.size(), 0);
      if (stall_prev) chk("stall_hold_valid", int'(m_valid), 1);
    end
    if (hs) begin
      chk("out_has_pending", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_tag", dp[LAT-1], e.tag);
        chk("out_last", int'(m_last), int'(e.last));
        hs_total++;
        if (e.last) fcnt = (fcnt + 1) % (1 << W_CNT);
      end
    end
    stall_prev = m_valid && !m_ready && !rst;
    @(posedge clk);
    if (rst) begin
      sb.delete();
      fcnt = 0;
      stall_prev = 0;
      for (int i = 0; i < LAT; i++) dp[i] = -1;
    end else if (c) begin
      for (int i = LAT - 1; i > 0; i--) dp[i] = dp[i-1];
      dp[0] = acc ? next_tag : -1;
      if (acc) begin
        e.tag  = next_tag;
        e.last = sl;
        sb.push_back(e);
        next_tag++;
      end
    end
  endtask

  initial begin
    int  nout;
    bit  ur_r, saw_top;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1; upd_req = 1'b0;
    for (int i = 0; i < LAT; i++) dp[i] = -1;
    @(posedge clk);

    // Reset with live inputs: all outputs stay low.
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 1, 0, 1);
      tick();
    end

    // Single vector, 3-vector frame, output stall, update request from IDLE.
    add(4'b1010, 6'b100100);
    for (int i = 0; i < 3; i++) add(4'b0010, 6'b100110);
    add(4'b0010, 6'b110110);
    add(4'b0010, 6'b100100);
    add(4'b1010, 6'b100100);
    add(4'b1010, 6'b100110);
    add(4'b1110, 6'b100110);
    add(4'b0010, 6'b100110);
    add(4'b0010, 6'b110110);
    add(4'b0010, 6'b110110);
    add(4'b0010, 6'b111110);
    add(4'b0010, 6'b100100);
    add(4'b1010, 6'b100100);
    for (int i = 0; i < 3; i++) add(4'b0010, 6'b100110);
    add(4'b0000, 6'b010010);
    add(4'b0000, 6'b010010);
    add(4'b0010, 6'b110110);
    add(4'b0010, 6'b100100);
    add(4'b1011, 6'b000100);
    add(4'b0001, 6'b000011);
    add(4'b0000, 6'b000011);
    add(4'b0010, 6'b100100);
    foreach (tbl[i]) begin
      drive(tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0], 0);
      chk($sformatf("table_row%0d", i), outs(), int'(tbl[i].exp));
      tick();
    end
    chk("frame_cnt_after_table", int'(frame_cnt), 1);

    // Update request in the middle of a stream: drain 4 in-flight, then grant.
    nout = 0;
    for (int t = 0; t < 15; t++) begin
      drive(t < 13, 0, 1, t >= 5 && t < 13, 0);
      if (t >= 5 && t < 13) chk("upd_blocks_s_ready", int'(s_ready), 0);
      if (t >= 5 && t <= 9) nout += int'(m_valid);
      chk($sformatf("upd_gnt_t%0d", t), int'(upd_gnt), int'(t >= 10 && t <= 13));
      if (t == 14) chk("idle_after_upd", int'({busy, s_ready}), 1);
      tick();
    end
    chk("drained_outputs", nout, 4);

    // Reset with two vectors in flight.
    drive(1, 0, 1, 0, 0); tick();
    drive(1, 0, 1, 0, 0); tick();
    drive(0, 0, 1, 0, 1); tick();
    for (int t = 0; t < 8; t++) begin
      drive(0, 0, 1, 0, 0);
      chk("no_valid_after_rst", int'(m_valid), 0);
      chk("idle_after_rst", int'(busy), 0);
      tick();
    end
    chk("frame_cnt_after_rst", int'(frame_cnt), 0);

    // Frame counter wrap: 2^W_CNT single-vector frames.
    saw_top = 0;
    hs_total = 0;
    for (int t = 0; t < (1 << W_CNT) + LAT + 2; t++) begin
      drive(t < (1 << W_CNT), 1, 1, 0, 0);
      if (frame_cnt == {W_CNT{1'b1}}) saw_top = 1;
      tick();
    end
    chk("wrap_saw_max", int'(saw_top), 1);
    chk("wrap_frames", hs_total, 1 << W_CNT);
    chk("wrap_to_zero", int'(frame_cnt), 0);

    // Random traffic with stalls, update requests and occasional resets.
    ur_r = 0;
    for (int t = 0; t < 3000; t++) begin
      if (ur_r) ur_r = ($urandom_range(0, 7) != 0);
      else      ur_r = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) != 0, ur_r, $urandom_range(0, 499) == 0);
      tick();
    end
    for (int t = 0; t < 3 * LAT; t++) begin
      drive(0, 0, 1, 0, 0);
      tick();
    end
    chk("random_all_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
